instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction decoder.
//  - Owns the program counter (PC) and issues one read at a time to instruction memory.
//  - Captures the returned 16-bit word in an instruction register and holds it for the decoder.
//  - Supports PC redirect for branches/jumps and downstream stall.
//  - Multi-cycle, one instruction in flight, no speculation.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_pc_counter.sv | 28 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions for the fetch stage (fetch FSM states,
// instruction field constants, WAIT detection helper).
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] EXT_WAIT = 4'b0000;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_RESP,
    FETCH_HOLD,
    FETCH_DRAIN
  } fetch_state_e;

  // WAIT is the R-type opcode with the WAIT extension in bits [7:4].
  function automatic logic is_wait_instr(input logic [INSTR_W-1:0] w);
    return (w[15:12] == OP_RTYPE) && (w[7:4] == EXT_WAIT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory read bus between the fetch unit
// (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rd_data,
    input  mem_rd_valid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rd_data,
    output mem_rd_valid
  );

endinterface

// File: rtl/fetch_pc_counter.sv
// fetch_pc_counter: program counter register with reset load, redirect load
// (highest priority) and modulo-2^ADDR_W increment.
module fetch_pc_counter #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] INC_STEP = ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + INC_STEP;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-issue instruction fetch stage feeding the decoder.
// Optional WAIT halting is compiled in by defining FETCH_HALT_ON_WAIT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic                stall,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_target,
  instr_fetch_unit_if.master  mem,
  output logic [INSTR_W-1:0]  instr_set,
  output logic                instr_valid,
  output logic                decoder_en,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                halted
);

  fetch_state_e      state, state_nx, resume;
  logic              valid_nx;
  logic              capture;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rd_data;

  assign rd_data      = mem.mem_rd_data;
  assign mem.mem_addr = pc;

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .target (pc_target),
    .inc    (capture),
    .pc     (pc)
  );

  // A redirect out of a halt always resumes fetching regardless of fetch_en.
  assign resume = (fetch_en || halted) ? FETCH_REQ : FETCH_IDLE;

  always_comb begin
    state_nx = state;
    valid_nx = instr_valid;
    capture  = 1'b0;
    if (pc_load) begin
      valid_nx = 1'b0;
      case (state)
        FETCH_REQ:               state_nx = FETCH_DRAIN;
        FETCH_RESP, FETCH_DRAIN: state_nx = mem.mem_rd_valid ? resume : FETCH_DRAIN;
        default:                 state_nx = resume;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (fetch_en && !halted) state_nx = FETCH_REQ;
        end
        FETCH_REQ: begin
          state_nx = FETCH_RESP;
        end
        FETCH_RESP: begin
          if (mem.mem_rd_valid) begin
            capture  = 1'b1;
            valid_nx = 1'b1;
            state_nx = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            valid_nx = 1'b0;
`ifdef FETCH_HALT_ON_WAIT_EN
            if (is_wait_instr(instr_set)) state_nx = FETCH_IDLE;
            else
`endif
            state_nx = fetch_en ? FETCH_REQ : FETCH_IDLE;
          end
        end
        FETCH_DRAIN: begin
          if (mem.mem_rd_valid) state_nx = fetch_en ? FETCH_REQ : FETCH_IDLE;
        end
        default: state_nx = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FETCH_IDLE;
      instr_set     <= '0;
      instr_valid   <= 1'b0;
      decoder_en    <= 1'b1;
      pc_out        <= RESET_PC;
      mem.mem_rd_en <= 1'b0;
    end else begin
      state         <= state_nx;
      instr_valid   <= valid_nx;
      decoder_en    <= ~valid_nx;
      mem.mem_rd_en <= (state_nx == FETCH_REQ);
      if (capture) begin
        instr_set <= rd_data[INSTR_W-1:0];
        pc_out    <= pc;
      end
    end
  end

`ifdef FETCH_HALT_ON_WAIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (pc_load) begin
      halted <= 1'b0;
    end else if (state == FETCH_HOLD && !stall && is_wait_instr(instr_set)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with a memory
// responder and a transaction-level fetch model checked every cycle.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        stall;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] instr_set;
  logic        instr_valid;
  logic        decoder_en;
  logic [15:0] pc_out;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  int unsigned lat     = 1;
  int unsigned rsp_cnt = 0;
  logic [15:0] rsp_addr;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .PC_INC   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem         (bus.master),
    .instr_set   (instr_set),
    .instr_valid (instr_valid),
    .decoder_en  (decoder_en),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event @%0t", name, $time);
  endtask

`ifdef FETCH_HALT_ON_WAIT_EN
  function automatic bit is_wait(input logic [15:0] w);
    return (w[15:12] == 4'h0) && (w[7:4] == 4'h0);
  endfunction
`endif

  // Memory responder: answers each request lat cycles later.
  initial begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      if (rsp_cnt != 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = mem[rsp_addr];
        end
      end
      if (bus.mem_rd_en) begin
        rsp_cnt  = lat;
        rsp_addr = bus.mem_addr;
      end
    end
  end

  // Fetch model: next fetch address, the outstanding request, and whether
  // its data has been invalidated by a redirect.
  logic [15:0] m_pc, out_addr, held_instr, held_pc;
  logic        out_stale, p_valid, p_load, p_stall, exp_halted;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_valid",  32'(instr_valid),   32'h0);
        chk("rst_dec_en", 32'(decoder_en),    32'h1);
        chk("rst_rd_en",  32'(bus.mem_rd_en), 32'h0);
        chk("rst_addr",   32'(bus.mem_addr),  32'h0);
        chk("rst_ir",     32'(instr_set),     32'h0);
        chk("rst_pc_out", 32'(pc_out),        32'h0);
        chk("rst_halted", 32'(halted),        32'h0);
        m_pc = 16'h0000; out_stale = 1'b1;
        p_valid = 1'b0; p_load = 1'b0; p_stall = 1'b0; exp_halted = 1'b0;
      end else begin
        chk("dec_en", 32'(decoder_en), 32'(!instr_valid));
        if (instr_valid && !p_valid) begin
          chk("capture_live", 32'(out_stale), 32'h0);
          chk("ir_data", 32'(instr_set), 32'(mem[out_addr]));
          chk("pc_out",  32'(pc_out),    32'(out_addr));
          held_instr = instr_set;
          held_pc    = pc_out;
          m_pc       = out_addr + 16'h0001;
          out_stale  = 1'b1;
        end else if (instr_valid && p_valid) begin
          chk("redirect_clear", 32'(p_load),  32'h0);
          chk("hold_consume",   32'(p_stall), 32'h1);
          chk("ir_stable",      32'(instr_set), 32'(held_instr));
          chk("pc_out_stable",  32'(pc_out),    32'(held_pc));
        end else if (!instr_valid && p_valid && !p_load) begin
          chk("stall_respected", 32'(p_stall), 32'h0);
`ifdef FETCH_HALT_ON_WAIT_EN
          if (is_wait(held_instr)) exp_halted = 1'b1;
`endif
        end
        chk("halted", 32'(halted), 32'(exp_halted));
        chk("one_in_flight", 32'(bus.mem_rd_en && instr_valid), 32'h0);
        if (bus.mem_rd_en) begin
          chk("req_addr", 32'(bus.mem_addr), 32'(m_pc));
          chk("req_while_halted", 32'(exp_halted), 32'h0);
          out_addr  = m_pc;
          out_stale = 1'b0;
        end
        if (pc_load) begin
          m_pc       = pc_target;
          out_stale  = 1'b1;
          exp_halted = 1'b0;
        end
        p_valid = instr_valid;
        p_load  = pc_load;
        p_stall = stall;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output logic [15:0] a);
    a = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        a = bus.mem_addr;
        return;
      end
    end
    timeout("wait_req");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    timeout("wait_valid");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  32'(instr_valid),   32'h0);
    chk({tag, "_dec_en"}, 32'(decoder_en),    32'h1);
    chk({tag, "_rd_en"},  32'(bus.mem_rd_en), 32'h0);
    chk({tag, "_addr"},   32'(bus.mem_addr),  32'h0);
    chk({tag, "_ir"},     32'(instr_set),     32'h0);
    chk({tag, "_pc_out"}, 32'(pc_out),        32'h0);
    chk({tag, "_halted"}, 32'(halted),        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h8000 | 16'(i * 37);
    mem[0] = 16'h0152;
    mem[5] = 16'h0300;

    reset = 1'b0; fetch_en = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_target = '0;
    cyc(3);
    chk_reset_outputs("reset");

    // First fetch, then hold it with stall.
    reset = 1'b1; fetch_en = 1'b1; stall = 1'b1;
    wait_req(a);
    chk("first_req", 32'(a), 32'h0);
    wait_valid();
    chk("first_ir",     32'(instr_set),  32'h0152);
    chk("first_pc_out", 32'(pc_out),     32'h0);
    chk("first_dec_en", 32'(decoder_en), 32'h0);
    chk("first_valid",  32'(instr_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_no_req", 32'(bus.mem_rd_en), 32'h0);
      chk("stall_ir",     32'(instr_set),     32'h0152);
      chk("stall_pc_out", 32'(pc_out),        32'h0);
      chk("stall_valid",  32'(instr_valid),   32'h1);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    wait_req(a);
    chk("next_req", 32'(a), 32'h1);
    cyc(6);

    // Redirect while waiting on a slow response.
    lat = 3;
    wait_req(a);
    @(posedge clk); #1;
    pc_load = 1'b1; pc_target = 16'h0040;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_req(a);
    chk("redirect_req", 32'(a), 32'h0040);

    // Address wrap at the top of memory.
    lat = 1; stall = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    pc_load = 1'b1; pc_target = 16'hFFFF; stall = 1'b0;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_req(a);
    chk("wrap_first", 32'(a), 32'hFFFF);
    wait_req(a);
    chk("wrap_next", 32'(a), 32'h0000);

    // Redirect while the request itself is on the bus.
    stall = 1'b1;
    wait_valid();
    lat = 3;
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    chk("req_state_rd_en", 32'(bus.mem_rd_en), 32'h1);
    pc_load = 1'b1; pc_target = 16'h0100;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_req(a);
    chk("drain_req", 32'(a), 32'h0100);

    // fetch_en dropped while holding: finish, then go quiet.
    lat = 1; stall = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    fetch_en = 1'b0; stall = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_req", 32'(bus.mem_rd_en), 32'h0);
      chk("idle_valid",  32'(instr_valid),   32'h0);
    end
    @(posedge clk); #1;
    fetch_en = 1'b1;
    wait_req(a);
    chk("resume_req", 32'(a), 32'h0101);

    // WAIT instruction at address 5.
    stall = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    pc_load = 1'b1; pc_target = 16'h0005; stall = 1'b0;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_valid();
    chk("wait_ir",     32'(instr_set), 32'h0300);
    chk("wait_pc_out", 32'(pc_out),    32'h0005);
    @(posedge clk); #1;
`ifdef FETCH_HALT_ON_WAIT_EN
    chk("wait_halted", 32'(halted),      32'h1);
    chk("wait_valid0", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_no_req", 32'(bus.mem_rd_en), 32'h0);
      chk("halt_held",   32'(halted),        32'h1);
    end
    @(posedge clk); #1;
    pc_load = 1'b1; pc_target = 16'h0010;
    @(posedge clk); #1;
    pc_load = 1'b0;
    chk("unhalt", 32'(halted), 32'h0);
    wait_req(a);
    chk("unhalt_req", 32'(a), 32'h0010);
`else
    chk("wait_not_halted", 32'(halted), 32'h0);
    wait_req(a);
    chk("after_wait_req", 32'(a), 32'h0006);
`endif

    // Reset during RESP with a slow response still in flight.
    lat = 3;
    wait_req(a);
    @(posedge clk); #1;
    reset = 1'b0; fetch_en = 1'b0;
    #1;
    chk_reset_outputs("resp_reset");
    cyc(2);
    reset = 1'b1;
    cyc(5);
    chk("stale_ignored", 32'(instr_valid), 32'h0);

    // Reset during HOLD.
    lat = 1; fetch_en = 1'b1; stall = 1'b1;
    wait_valid();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk_reset_outputs("hold_reset");
    cyc(2);
    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
